// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-N stream demultiplexer.
// Each output channel owns a one-entry holding register. The target is
// picked from in_sel, or from an internal round-robin pointer when RR_MODE=1.
// A select beyond the last channel is accepted and discarded, which raises
// a one-cycle drop pulse and a sticky err flag.
module stream_demux_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int RR_MODE  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]          rr_ptr,
  output logic                      drop,
  output logic                      err
);

  logic [CHANNELS-1:0]            valid_q, valid_d;
  logic [CHANNELS-1:0][WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0]               rr_q, rr_d;
  logic                           drop_q, drop_d;
  logic                           err_q, err_d;

  logic [SEL_W-1:0]    tgt;
  logic                oor;
  logic                tgt_free;
  logic                accept;
  logic [CHANNELS-1:0] slot_free;
  logic [CHANNELS-1:0] wr;

  // Resolve the target channel and whether it can take a word this cycle.
  always_comb begin
    tgt       = (RR_MODE != 0) ? rr_q : in_sel;
    oor       = (32'(tgt) >= CHANNELS);
    // A slot is free if empty, or if its consumer drains it this cycle.
    slot_free = ~valid_q | out_ready;
    tgt_free  = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (32'(tgt) == k) tgt_free = slot_free[k];
    end
  end

  // Out-of-range targets are always accepted so the producer never deadlocks.
  assign in_ready = en & (oor | tgt_free);
  assign accept   = in_valid & in_ready;

  // Next-state: per-channel refill/drain, round-robin advance, drop/err flags.
  always_comb begin
    wr      = '0;
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < CHANNELS; k++) begin
      wr[k]      = accept & ~oor & (32'(tgt) == k);
      // Refill wins over drain, so a slot can turn over in a single cycle.
      valid_d[k] = wr[k] | (valid_q[k] & ~out_ready[k]);
      if (wr[k]) data_d[k] = in_data;
    end
    drop_d = accept & oor;
    err_d  = err_q | drop_d;
    rr_d   = rr_q;
    if ((RR_MODE != 0) && accept) begin
      rr_d = (32'(rr_q) >= CHANNELS - 1) ? '0 : rr_q + SEL_W'(1);
    end
  end

  // State registers; reset discards any held words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      rr_q    <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign rr_ptr    = rr_q;
  assign drop      = drop_q;
  assign err       = err_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// Testbench for stream_demux_n: three instances (select-routed x4,
// select-routed x3, round-robin x4) with a scoreboard per routed stream.
module tb_stream_demux_n;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
  } exp_t;

  logic clk;
  logic rst_n;
  logic en;
  logic [7:0] in_data;
  logic [1:0] in_sel;

  // Instance A: CHANNELS=4, select routing
  logic        a_valid, a_ready;
  logic [3:0]  a_ov, a_or;
  logic [31:0] a_od;
  logic [1:0]  a_rr;
  logic        a_drop, a_err;

  // Instance B: CHANNELS=3, select routing
  logic        b_valid, b_ready;
  logic [2:0]  b_ov, b_or;
  logic [23:0] b_od;
  logic [1:0]  b_rr;
  logic        b_drop, b_err;

  // Instance C: CHANNELS=4, round-robin
  logic        c_valid, c_ready;
  logic [3:0]  c_ov, c_or;
  logic [31:0] c_od;
  logic [1:0]  c_rr;
  logic        c_drop, c_err;

  int checks = 0;
  int failures = 0;
  exp_t exp_a[$];
  exp_t exp_c[$];

  stream_demux_n #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .RR_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(a_ov), .out_ready(a_or),
    .out_data(a_od), .rr_ptr(a_rr), .drop(a_drop), .err(a_err));

  stream_demux_n #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .RR_MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(b_ov), .out_ready(b_or),
    .out_data(b_od), .rr_ptr(b_rr), .drop(b_drop), .err(b_err));

  stream_demux_n #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .RR_MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(c_valid), .in_ready(c_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(c_ov), .out_ready(c_or),
    .out_data(c_od), .rr_ptr(c_rr), .drop(c_drop), .err(c_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [1:0] ch, input logic [7:0] d);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    return e;
  endfunction

  // Monitor A: every drained word must match an outstanding expectation for that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (a_ov[k] && a_or[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < exp_a.size(); i++) begin
            if (idx < 0 && exp_a[i].ch == 2'(k)) idx = i;
          end
          if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected ch=%0d actual=%0h required=none", k, a_od[k*8 +: 8]);
          end else begin
            chk($sformatf("a_data_ch%0d", k), 32'(a_od[k*8 +: 8]), 32'(exp_a[idx].d));
            exp_a.delete(idx);
          end
        end
      end
    end
  end

  // Monitor C: round-robin output must come out in issue order on the expected channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (c_ov[k] && c_or[k]) begin
          if (exp_c.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL c_unexpected ch=%0d actual=%0h required=none", k, c_od[k*8 +: 8]);
          end else begin
            exp_t e;
            e = exp_c.pop_front();
            chk("c_channel", 32'(k), 32'(e.ch));
            chk("c_data", 32'(c_od[k*8 +: 8]), 32'(e.d));
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; in_data = '0; in_sel = '0;
    a_valid = 0; b_valid = 0; c_valid = 0;
    a_or = '0; b_or = '0; c_or = '0;

    // 1. reset then idle
    cyc(); cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a_out_valid", 32'(a_ov), 0);
    chk("rst_a_out_data", a_od, 0);
    chk("rst_a_err", 32'(a_err), 0);
    chk("rst_a_rr_ptr", 32'(a_rr), 0);
    chk("rst_a_in_ready", 32'(a_ready), 1);
    chk("rst_b_err", 32'(b_err), 0);
    chk("rst_c_rr_ptr", 32'(c_rr), 0);

    // 2. select routing, back-to-back
    a_or = 4'hF;
    cyc();
    a_valid = 1; in_sel = 2; in_data = 8'hA5;
    @(negedge clk);
    chk("sel_in_ready0", 32'(a_ready), 1);
    exp_a.push_back(mk(2, 8'hA5));
    cyc();
    in_sel = 0; in_data = 8'h3C;
    @(negedge clk);
    chk("sel_in_ready1", 32'(a_ready), 1);
    chk("sel_out_valid0", 32'(a_ov), 32'b0100);
    chk("sel_data_ch2", 32'(a_od[23:16]), 32'hA5);
    exp_a.push_back(mk(0, 8'h3C));
    cyc();
    a_valid = 0;
    @(negedge clk);
    chk("sel_out_valid1", 32'(a_ov), 32'b0001);
    chk("sel_data_ch0", 32'(a_od[7:0]), 32'h3C);

    // 3. backpressure on channel 1
    cyc();
    a_or = 4'b1101;
    a_valid = 1; in_sel = 1; in_data = 8'h11;
    @(negedge clk);
    chk("bp_in_ready_11", 32'(a_ready), 1);
    exp_a.push_back(mk(1, 8'h11));
    cyc();
    in_data = 8'h22;
    @(negedge clk);
    chk("bp_in_ready_22a", 32'(a_ready), 0);
    chk("bp_out_valid", 32'(a_ov), 32'b0010);
    cyc();
    @(negedge clk);
    chk("bp_in_ready_22b", 32'(a_ready), 0);
    chk("bp_hold_11", 32'(a_od[15:8]), 32'h11);
    cyc();
    a_or = 4'hF;
    @(negedge clk);
    chk("bp_in_ready_22c", 32'(a_ready), 1);
    exp_a.push_back(mk(1, 8'h22));
    cyc();
    in_sel = 3; in_data = 8'h33;
    @(negedge clk);
    chk("bp_in_ready_33", 32'(a_ready), 1);
    chk("bp_refill_valid", 32'(a_ov), 32'b0010);
    exp_a.push_back(mk(3, 8'h33));
    cyc();
    a_valid = 0;
    @(negedge clk);
    chk("bp_out_valid_33", 32'(a_ov), 32'b1000);

    // 4. enable gating while channel 0 drains
    cyc();
    a_or = 4'b0000;
    a_valid = 1; in_sel = 0; in_data = 8'h5A;
    @(negedge clk);
    exp_a.push_back(mk(0, 8'h5A));
    cyc();
    en = 0; in_sel = 2; in_data = 8'h77;
    @(negedge clk);
    chk("en_in_ready0", 32'(a_ready), 0);
    chk("en_out_valid0", 32'(a_ov), 32'b0001);
    cyc();
    a_or = 4'b0001;
    @(negedge clk);
    chk("en_in_ready1", 32'(a_ready), 0);
    cyc();
    @(negedge clk);
    chk("en_out_valid1", 32'(a_ov), 32'b0000);
    cyc();
    en = 1; a_valid = 0;

    // 5. out-of-range select on the three-channel instance
    b_or = 3'b111;
    b_valid = 1; in_sel = 3; in_data = 8'hFF;
    @(negedge clk);
    chk("oor_in_ready", 32'(b_ready), 1);
    chk("oor_drop_pre", 32'(b_drop), 0);
    cyc();
    b_valid = 0;
    @(negedge clk);
    chk("oor_drop", 32'(b_drop), 1);
    chk("oor_err", 32'(b_err), 1);
    chk("oor_out_valid", 32'(b_ov), 0);
    cyc();
    @(negedge clk);
    chk("oor_drop_pulse", 32'(b_drop), 0);
    chk("oor_err_sticky", 32'(b_err), 1);

    // 6. round-robin sequence, then reset mid-stream
    c_or = 4'hF;
    for (int i = 0; i < 5; i++) begin
      cyc();
      c_valid = 1; in_sel = 2'(3 - (i % 4)); in_data = 8'(i + 1);
      @(negedge clk);
      chk($sformatf("rr_ptr_%0d", i), 32'(c_rr), 32'(i % 4));
      chk($sformatf("rr_in_ready_%0d", i), 32'(c_ready), 1);
      exp_c.push_back(mk(2'(i % 4), 8'(i + 1)));
    end
    cyc();
    c_valid = 0;
    @(negedge clk);
    chk("rr_ptr_5", 32'(c_rr), 1);
    cyc();
    c_valid = 1; in_data = 8'h06;
    @(negedge clk);
    exp_c.push_back(mk(1, 8'h06));
    cyc();
    in_data = 8'h07;
    @(negedge clk);
    chk("rr_ptr_7", 32'(c_rr), 2);
    @(posedge clk);
    #1;
    c_valid = 0;
    chk("rr_pre_rst_valid", 32'(c_ov), 32'b0100);
    chk("rr_pre_rst_ptr", 32'(c_rr), 3);
    #2;
    rst_n = 1'b0;
    exp_c.delete();
    #1;
    chk("rr_rst_ptr", 32'(c_rr), 0);
    chk("rr_rst_valid", 32'(c_ov), 0);
    chk("rst_b_err_clr", 32'(b_err), 0);
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();

    chk("a_pending", 32'(exp_a.size()), 0);
    chk("c_pending", 32'(exp_c.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
